// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, IF/ID bundle and reset defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          IFID_W        = 97;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.instr = nop;
    b.pc    = '0;
    b.pc4   = '0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with imem, holds the IF/ID register.
// Handshake: imem_req/imem_addr stay stable from rise until a cycle with imem_ready=1; that cycle completes.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [5:0]  op_o,
  output logic [5:0]  funct_o,
  output logic [1:0]  state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  ifid_t        ifid_q, ifid_d;
  ifid_t        buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;

  logic [31:0]  pc_plus4;
  ifid_t        fetched;

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    fetched.instr = imem_rdata;
    fetched.pc    = pc_q;
    fetched.pc4   = pc_plus4;
    fetched.valid = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ifid_d       = ifid_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    if (state_q == ST_IDLE) begin
      state_d = ST_FETCH;
    end else if (redirect_i) begin
      // Redirect wins over stall and completion; a word returned this cycle is dropped.
      ifid_d      = ifid_bubble(NOP_INSTR);
      buf_valid_d = 1'b0;
      pc_d        = {redirect_pc_i[31:2], 2'b00};
      case (state_q)
        ST_FETCH: if (!imem_ready) begin
          drain_addr_d = pc_q;
          state_d      = ST_DRAIN;
        end
        ST_HOLD:  state_d = ST_FETCH;
        ST_DRAIN: if (imem_ready) state_d = ST_FETCH;
        default:  ;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: if (imem_ready) begin
          pc_d = pc_plus4;
          if (stall_i) begin
            buf_d       = fetched;
            buf_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            ifid_d = fetched;
          end
        end
        ST_HOLD: if (!stall_i) begin
          ifid_d       = buf_q;
          ifid_d.valid = buf_valid_q;
          buf_valid_d  = 1'b0;
          state_d      = ST_FETCH;
        end
        ST_DRAIN: if (imem_ready) state_d = ST_FETCH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      ifid_q       <= ifid_bubble(NOP_INSTR);
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ifid_q       <= ifid_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
    end
  end

  assign instr_o    = ifid_q.instr;
  assign pc_o       = ifid_q.pc;
  assign pc_plus4_o = ifid_q.pc4;
  assign valid_o    = ifid_q.valid;
  assign op_o       = ifid_q.instr[31:26];
  assign funct_o    = ifid_q.instr[5:0];
  assign state_o    = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode controller.
- Owns the PC and runs a req/ready handshake with instruction memory.
- Holds the IF/ID pipeline register, whose op/funct fields drive the controller.
- Supports stall (hazard hold via a one-entry skid buffer) and redirect (taken branch/jump, with discard of in-flight fetches).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, word presented when the IF/ID slot is invalid (sll $0,$0,0).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
stall_i  input  1  hazard unit: hold IF/ID contents
redirect_i  input  1  taken branch or jump resolved in ID
redirect_pc_i  input  32  redirect target; bits [1:0] ignored, forced 00
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, word aligned
imem_ready  input  1  memory accepts and returns in the same cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready
instr_o  output  32  IF/ID instruction
pc_o  output  32  IF/ID PC
pc_plus4_o  output  32  IF/ID PC+4
valid_o  output  1  IF/ID slot holds a real instruction
op_o  output  6  instr_o[31:26], to controller op
funct_o  output  6  instr_o[5:0], to controller funct

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, buf_valid=0.
  - instr_o=NOP_INSTR, pc_o=0, pc_plus4_o=0, valid_o=0.
  - imem_req=0, imem_addr=RESET_PC.
  - Reset mid-transaction abandons it; memory must tolerate req dropping.
- States: IDLE, FETCH, DRAIN, HOLD.
  - IDLE -> FETCH unconditionally, one cycle after reset release.
- Request generation and addressing:
  - imem_req = (state==FETCH || state==DRAIN); combinational from state.
  - imem_addr = pc in FETCH; drain_addr in DRAIN.
  - Once req rises, req and addr are held stable until a cycle with imem_ready=1. No retraction except reset.
  - Completion = imem_req && imem_ready. One-cycle fetch is possible when ready is already high.
- FETCH, completion, no redirect, stall_i=0:
  - IF/ID <= {imem_rdata, pc, pc+4, valid=1}; pc <= pc+4; stay in FETCH.
- FETCH, completion, no redirect, stall_i=1:
  - word, pc and pc+4 go into the skid buffer; buf_valid=1; pc <= pc+4; -> HOLD.
  - IF/ID unchanged.
- HOLD (req=0):
  - When stall_i=0: IF/ID <= buffer, buf_valid=0, -> FETCH.
  - While stall_i=1: stay in HOLD.
- Stall without completion: IF/ID holds; the request continues.
- Redirect (priority over stall and completion), any state except IDLE:
  - IF/ID <= {NOP_INSTR, 0, 0, valid=0}; buf_valid=0; pc <= {redirect_pc_i[31:2],2'b00}.
  - If state is FETCH, req is high and imem_ready=0: drain_addr <= old pc, -> DRAIN.
  - If the request completes in the redirect cycle: the word is discarded, -> FETCH.
  - From HOLD: -> FETCH.
  - In DRAIN: retarget pc and stay in DRAIN.
- DRAIN: wait for completion, discard rdata, -> FETCH, which then fetches the redirected pc.
- A redirect in IDLE is ignored.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- op_o and funct_o are pure slices of instr_o. An invalid slot therefore decodes as op=0, funct=0.
- Latency: a word accepted in cycle N appears on instr_o in cycle N+1 (no stall).
- Throughput: one instruction per cycle while imem_ready=1.

Decomposition:
- Shared package fetch_pkg:
  - state encoding IDLE/FETCH/DRAIN/HOLD (2-bit);
  - NOP_INSTR;
  - RESET_PC default;
  - IF/ID bundle width (97 bits: instr+pc+pc4+valid).
- No sub-module required. The skid buffer is three registers plus buf_valid, kept inline.

Test Plan:
- Reset, then imem_ready tied 1 with memory word = address:
  - required: valid_o=0 during reset and the IDLE cycle;
  - then instr_o = 0x0, 0x4, 0x8 on consecutive cycles;
  - pc_plus4_o = pc_o+4.
- imem_ready low 3 cycles on fetch of 0x8:
  - required: imem_addr stable at 0x8 and req held for all 4 cycles;
  - IF/ID holds 0x4 until completion; no duplicate or lost word.
- stall_i high 2 cycles while fetch of 0xC completes:
  - required: instr_o stays 0x8, state HOLD, req=0;
  - after the stall drops, instr_o=0xC, then 0x10.
- redirect_i with redirect_pc_i=0x103 while 0x10 is pending (ready=0) for 2 more cycles:
  - required: valid_o=0 next cycle, DRAIN keeps addr 0x10;
  - the returned word is discarded; next request addr 0x100; instr_o=0x100 with valid_o=1.
- redirect_i and stall_i asserted together with buf_valid=1:
  - required: buffer cleared, valid_o=0, next fetch at the redirect target.
- Redirect to 0xFFFFFFFC:
  - required: instr_o pc_o=0xFFFFFFFC, pc_plus4_o=0x0;
  - next request addr 0x00000000.
